// File: rtl/wb_mem_slave.sv
// Wishbone classic slave memory: configurable width/depth/wait states,
// byte-lane writes, error termination for out-of-range words, backdoor preload.
module wb_mem_slave #(
  parameter int unsigned DW          = 16,
  parameter int unsigned AW          = 16,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [AW-1:0]            wb_adr_i,
  input  logic [DW/8-1:0]          wb_sel_i,
  input  logic [DW-1:0]            wb_dat_i,
  output logic [DW-1:0]            wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  input  logic                     tb_we,
  input  logic [$clog2(DEPTH)-1:0] tb_addr,
  input  logic [DW-1:0]            tb_wdata
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned OB = $clog2(NB);
  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            oor_q, oor_d;
  logic            we_q, we_d;
  logic [NB-1:0]   sel_q, sel_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic [DW-1:0]   dat_q, dat_d;

  logic [DW-1:0]   mem [DEPTH];

  logic [31:0]     in_idx32;
  logic            in_oor;
  logic [IW-1:0]   in_idx;
  logic            req;
  logic            load_rd;
  logic [IW-1:0]   rd_idx;
  logic            rd_oor;
  logic            bus_wr;

  assign in_idx32 = 32'(wb_adr_i) >> OB;
  assign in_oor   = (in_idx32 >= DEPTH);
  assign in_idx   = in_idx32[IW-1:0];
  assign req      = wb_cyc_i & wb_stb_i;

  // With zero wait states the read happens on the sampling edge, so the
  // index comes straight from the bus rather than from the latched copy.
  assign rd_idx = (state_q == S_IDLE) ? in_idx : idx_q;
  assign rd_oor = (state_q == S_IDLE) ? in_oor : oor_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    oor_d   = oor_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    dat_d   = dat_q;
    load_rd = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d  = in_idx;
          oor_d  = in_oor;
          we_d   = wb_we_i;
          sel_d  = wb_sel_i;
          wdat_d = wb_dat_i;
          cnt_d  = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            load_rd = !wb_we_i;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_RESP;
            load_rd = !we_q;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (load_rd) begin
      dat_d = rd_oor ? '0 : mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      dat_q   <= dat_d;
    end
  end

  assign bus_wr = (state_q == S_RESP) && we_q && !oor_q && !rst;

  // Backdoor first, bus lanes after: on a same-word collision the later
  // per-lane assignment wins, leaving the backdoor value in unselected lanes.
  always_ff @(posedge clk) begin
    if (tb_we) begin
      mem[tb_addr] <= tb_wdata;
    end
    if (bus_wr) begin
      for (int unsigned l = 0; l < NB; l++) begin
        if (sel_q[l]) begin
          mem[idx_q][l*8 +: 8] <= wdat_q[l*8 +: 8];
        end
      end
    end
  end

  assign wb_ack_o = (state_q == S_RESP) && !oor_q && !rst;
  assign wb_err_o = (state_q == S_RESP) &&  oor_q && !rst;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Bench for wb_mem_slave: three instances (0, 1 and 3 wait states) checked
// against a word-array model via vector table, hand sequences and random traffic.
module tb_wb_mem_slave;

  typedef struct {
    int          d;
    bit          w;
    logic [15:0] a;
    logic [1:0]  s;
    logic [15:0] wd;
    bit          e;
    logic [15:0] rd;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc [3];
  logic        stb [3];
  logic        we [3];
  logic [15:0] adr [3];
  logic [1:0]  sel [3];
  logic [15:0] wdat [3];
  logic [15:0] rdat [3];
  logic        ack [3];
  logic        err [3];
  logic        bwe [3];
  logic [9:0]  baddr [3];
  logic [15:0] bdata [3];

  logic [15:0] mdl [3][1024];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_mem_slave #(
      .DW(16),
      .AW(16),
      .DEPTH(1024),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .wb_cyc_i(cyc[g]),
      .wb_stb_i(stb[g]),
      .wb_we_i(we[g]),
      .wb_adr_i(adr[g]),
      .wb_sel_i(sel[g]),
      .wb_dat_i(wdat[g]),
      .wb_dat_o(rdat[g]),
      .wb_ack_o(ack[g]),
      .wb_err_o(err[g]),
      .tb_we(bwe[g]),
      .tb_addr(baddr[g]),
      .tb_wdata(bdata[g])
    );
  end

  function automatic int ws_of(int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void mwrite(int d, int idx, logic [1:0] s, logic [15:0] v);
    if (s[0]) mdl[d][idx][7:0]  = v[7:0];
    if (s[1]) mdl[d][idx][15:8] = v[15:8];
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 3; d++) chk("ack_err_excl", 32'(ack[d] & err[d]), 0);
    end
  end

  task automatic bd(input int d, input int idx, input logic [15:0] v);
    @(negedge clk);
    bwe[d] = 1'b1; baddr[d] = 10'(idx); bdata[d] = v;
    @(negedge clk);
    bwe[d] = 1'b0;
    mdl[d][idx] = v;
  endtask

  task automatic xfer(input int d, input bit w, input logic [15:0] a, input logic [1:0] s,
                      input logic [15:0] wd, output bit ga, output bit ge,
                      output logic [15:0] rd, output int lat);
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; wdat[d] = wd;
    ga = 1'b0; ge = 1'b0; rd = '0; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ack[d] || err[d]) begin
        ga = ack[d]; ge = err[d]; rd = rdat[d]; lat = i;
        break;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(posedge clk);
  endtask

  task automatic run_check(input string nm, input vec_t v);
    bit ga, ge;
    logic [15:0] rd;
    int lat;
    xfer(v.d, v.w, v.a, v.s, v.wd, ga, ge, rd, lat);
    chk({nm, "_ack"}, 32'(ga), 32'(!v.e));
    chk({nm, "_err"}, 32'(ge), 32'(v.e));
    chk({nm, "_lat"}, 32'(lat), 32'(v.lat));
    if (!v.w) chk({nm, "_rdata"}, 32'(rd), 32'(v.rd));
    if (v.w && !v.e) mwrite(v.d, int'(v.a >> 1), v.s, v.wd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt [14];
    vec_t rv;
    bit ga, ge;
    logic [15:0] rd, hold;
    int lat, e, last;
    bit got;

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      cyc[d] = 0; stb[d] = 0; we[d] = 0; adr[d] = '0; sel[d] = '0; wdat[d] = '0;
      bwe[d] = 0; baddr[d] = '0; bdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_ack", 32'(ack[d]), 0);
      chk("reset_err", 32'(err[d]), 0);
      chk("reset_dat", 32'(rdat[d]), 0);
    end
    rst = 1'b0;

    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        bwe[d] = 1'b1; baddr[d] = 10'(i); bdata[d] = 16'($urandom);
        mdl[d][i] = bdata[d];
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) bwe[d] = 1'b0;
    mon_en = 1'b1;

    bd(2, 2, 16'h1234);
    bd(0, 5, 16'hAAAA);
    bd(0, 0, 16'h0F0F);
    bd(1, 16'h80, 16'h0000);

    vt[0]  = '{0, 1'b1, 16'h0010, 2'b11, 16'hBEEF, 1'b0, 16'h0000, 1};
    vt[1]  = '{0, 1'b0, 16'h0010, 2'b11, 16'h0000, 1'b0, 16'hBEEF, 1};
    vt[2]  = '{0, 1'b0, 16'h0011, 2'b00, 16'h0000, 1'b0, 16'hBEEF, 1};
    vt[3]  = '{2, 1'b0, 16'h0004, 2'b00, 16'h0000, 1'b0, 16'h1234, 4};
    vt[4]  = '{0, 1'b1, 16'h000A, 2'b01, 16'h55FF, 1'b0, 16'h0000, 1};
    vt[5]  = '{0, 1'b0, 16'h000A, 2'b00, 16'h0000, 1'b0, 16'hAAFF, 1};
    vt[6]  = '{0, 1'b0, 16'h0800, 2'b00, 16'h0000, 1'b1, 16'h0000, 1};
    vt[7]  = '{0, 1'b1, 16'h0800, 2'b11, 16'hDEAD, 1'b1, 16'h0000, 1};
    vt[8]  = '{0, 1'b0, 16'h0000, 2'b00, 16'h0000, 1'b0, 16'h0F0F, 1};
    vt[9]  = '{2, 1'b1, 16'h07FE, 2'b11, 16'hC0DE, 1'b0, 16'h0000, 4};
    vt[10] = '{2, 1'b0, 16'h07FE, 2'b00, 16'h0000, 1'b0, 16'hC0DE, 4};
    vt[11] = '{2, 1'b0, 16'hFFFF, 2'b00, 16'h0000, 1'b1, 16'h0000, 4};
    vt[12] = '{1, 1'b1, 16'h0100, 2'b10, 16'hA5A5, 1'b0, 16'h0000, 2};
    vt[13] = '{1, 1'b0, 16'h0100, 2'b00, 16'h0000, 1'b0, 16'hA500, 2};
    for (int i = 0; i < 14; i++) run_check($sformatf("vec%0d", i), vt[i]);

    // Backdoor/bus collision on the commit edge
    bd(0, 7, 16'h1111);
    @(negedge clk);
    cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 16'h000E; sel[0] = 2'b01; wdat[0] = 16'hABCD;
    @(posedge clk); #1;
    chk("coll_ack", 32'(ack[0]), 1);
    cyc[0] = 0; stb[0] = 0;
    bwe[0] = 1; baddr[0] = 10'd7; bdata[0] = 16'h2222;
    @(posedge clk); #1;
    bwe[0] = 0;
    mdl[0][7] = 16'h2222;
    mwrite(0, 7, 2'b01, 16'hABCD);
    rv = '{0, 1'b0, 16'h000E, 2'b00, 16'h0000, 1'b0, mdl[0][7], 1};
    run_check("coll_read", rv);

    // Read data holds after ack; stb without cyc is ignored
    xfer(1, 1'b0, 16'h0040, 2'b00, 16'h0000, ga, ge, hold, lat);
    chk("hold_first", 32'(hold), 32'(mdl[1][32]));
    @(negedge clk);
    stb[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("stb_only_ackerr", 32'({ack[1], err[1]}), 0);
      chk("hold_dat", 32'(rdat[1]), 32'(mdl[1][32]));
    end
    stb[1] = 1'b0;

    // Abort by dropping cyc in the second wait cycle
    @(negedge clk);
    cyc[2] = 1; stb[2] = 1; we[2] = 1; adr[2] = 16'h0020; sel[2] = 2'b11; wdat[2] = 16'h7777;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc[2] = 0; stb[2] = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("abort_ackerr", 32'({ack[2], err[2]}), 0);
    end
    rv = '{2, 1'b0, 16'h0020, 2'b00, 16'h0000, 1'b0, mdl[2][16], 4};
    run_check("abort_read", rv);

    // Reset in the wait phase drops the transfer
    @(negedge clk);
    cyc[2] = 1; stb[2] = 1; we[2] = 1; adr[2] = 16'h0020; sel[2] = 2'b11; wdat[2] = 16'h7777;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstw_ack", 32'(ack[2]), 0);
    chk("rstw_err", 32'(err[2]), 0);
    chk("rstw_dat", 32'(rdat[2]), 0);
    rst = 1'b0; cyc[2] = 0; stb[2] = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("rstw_ackerr", 32'({ack[2], err[2]}), 0);
    end
    run_check("rstw_read", rv);

    // Back-to-back reads with stb held, one wait state
    @(negedge clk);
    cyc[1] = 1; stb[1] = 1; we[1] = 0; adr[1] = 16'h0200; sel[1] = 2'b00;
    e = 0; last = 0;
    for (int i = 0; i < 8; i++) begin
      got = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        e++;
        if (ack[1]) begin got = 1; break; end
      end
      chk("b2b_ack", 32'(got), 1);
      chk("b2b_gap", 32'(e - last), (i == 0) ? 2 : 3);
      chk("b2b_rdata", 32'(rdat[1]), 32'(mdl[1][256 + i]));
      last = e;
      adr[1] = 16'(16'h0200 + 2 * (i + 1));
    end
    cyc[1] = 0; stb[1] = 0;
    @(posedge clk);

    // Random traffic against the word-array model
    for (int n = 0; n < 300; n++) begin
      rv.d = int'($urandom_range(0, 2));
      rv.w = 1'($urandom_range(0, 1));
      rv.a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2047));
      rv.s = 2'($urandom);
      rv.wd = 16'($urandom);
      rv.e = (rv.a >= 16'h0800);
      rv.rd = rv.e ? 16'h0000 : mdl[rv.d][int'(rv.a >> 1)];
      rv.lat = 1 + ws_of(rv.d);
      run_check("rand", rv);
    end

    // Full scan of instance 0 for stray writes
    for (int i = 0; i < 1024; i++) begin
      xfer(0, 1'b0, 16'(2 * i), 2'b00, 16'h0000, ga, ge, rd, lat);
      chk($sformatf("scan%0d", i), 32'(rd), 32'(mdl[0][i]));
    end

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
